// File: rtl/chess_move_pkg.sv
// Shared move format, FIFO word geometry and sequencer state encoding for the
// board-level move sequencer and its arbiter.
package chess_move_pkg;

  localparam int NCOL          = 8;
  localparam int SLOTS         = 8;
  localparam int MOVE_W        = 19;
  localparam int COL_WORD_W    = SLOTS * MOVE_W;
  localparam int LAUNCH_CYCLES = 2;
  localparam int PTR_W         = $clog2(NCOL);

  localparam int BIT_INV    = 18;
  localparam int BIT_PROMO  = 17;
  localparam int BIT_PAWN   = 16;
  localparam int BIT_PAWN2  = 15;
  localparam int BIT_EP     = 14;
  localparam int BIT_CASTLE = 13;
  localparam int BIT_CAP    = 12;
  localparam int FROM_HI    = 11;
  localparam int FROM_LO    = 6;
  localparam int TO_HI      = 5;
  localparam int TO_LO      = 0;

  typedef logic [MOVE_W-1:0] move_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SCAN,
    ST_READ,
    ST_CAPT,
    ST_EMIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter8.sv
// Rotating-priority arbiter: grants the first requester at or after i_ptr,
// wrapping from the top column back to column 0.
module rr_arbiter8
  import chess_move_pkg::*;
(
  input  logic [NCOL-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NCOL-1:0]  o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  logic [PTR_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NCOL; k++) begin
      w_cand = i_ptr + PTR_W'(k);
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
        o_grant = NCOL'(1) << w_cand;
      end
    end
  end

endmodule

// File: rtl/board_move_sequencer.sv
// Launches a move-generation pass, drains the column FIFOs round-robin and streams valid moves.
// States: IDLE idle | LAUNCH col_reset pulse | SCAN arbitrate | READ pop FIFO | CAPT latch word | EMIT stream slots | DONE pass finished
module board_move_sequencer
  import chess_move_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic [NCOL-1:0]              col_reset,
  input  logic [NCOL-1:0]              col_done,
  input  logic [NCOL-1:0]              col_empty,
  output logic [NCOL-1:0]              col_rden,
  input  logic [NCOL*COL_WORD_W-1:0]   col_data,
  output logic                         move_valid,
  input  logic                         move_ready,
  output logic [MOVE_W-1:0]            move_data,
  output logic [7:0]                   move_count,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int LC_W = $clog2(LAUNCH_CYCLES + 1);

  state_e r_state, w_next;

  logic [PTR_W-1:0]                     r_rr_ptr;
  logic [PTR_W-1:0]                     r_gnt_idx;
  logic [NCOL-1:0]                      r_gnt_onehot;
  logic [SLOTS-1:0][MOVE_W-1:0]         r_buf;
  logic [$clog2(SLOTS)-1:0]             r_slot;
  logic [LC_W-1:0]                      r_launch_cnt;
  logic [WD_W-1:0]                      r_wdog;
  logic                                 r_error;
  logic [7:0]                           r_move_count;

  logic [NCOL-1:0][SLOTS-1:0][MOVE_W-1:0] w_col_words;
  logic [NCOL-1:0]                      w_arb_grant;
  logic [PTR_W-1:0]                     w_arb_idx;
  logic                                 w_arb_valid;
  move_t                                w_slot_move;
  logic                                 w_slot_inv;
  logic                                 w_start_ok;
  logic                                 w_wdog_active;
  logic                                 w_wdog_tc;
  logic                                 w_emit_valid;
  logic                                 w_accept;
  logic                                 w_advance;
  logic                                 w_last_slot;

  rr_arbiter8 u_arb (
    .i_req   (~col_empty),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_col_words   = col_data;
  assign w_slot_move   = r_buf[r_slot];
  assign w_slot_inv    = w_slot_move[BIT_INV];
  assign w_last_slot   = (r_slot == $clog2(SLOTS)'(SLOTS - 1));
  assign w_start_ok    = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_wdog_active = (r_state == ST_SCAN) || (r_state == ST_READ) ||
                         (r_state == ST_CAPT) || (r_state == ST_EMIT);
  assign w_wdog_tc     = w_wdog_active && (r_wdog == '0);
  // A move is never offered in the expiry cycle, so nothing is accepted mid-abort.
  assign w_emit_valid  = (r_state == ST_EMIT) && !w_slot_inv && !w_wdog_tc;
  assign w_accept      = w_emit_valid && move_ready;
  assign w_advance     = (r_state == ST_EMIT) && (w_slot_inv || w_accept);

  assign move_count = r_move_count;
  assign error      = r_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    col_reset  = '0;
    col_rden   = '0;
    move_valid = 1'b0;
    move_data  = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        col_reset = '1;
        if (r_launch_cnt == '0) w_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_arb_valid)    w_next = ST_READ;
        else if (&col_done) w_next = ST_DONE;
      end
      ST_READ: begin
        col_rden = r_gnt_onehot;
        w_next   = ST_CAPT;
      end
      ST_CAPT: begin
        w_next = ST_EMIT;
      end
      ST_EMIT: begin
        move_valid = w_emit_valid;
        move_data  = w_slot_move;
        if (w_advance && w_last_slot) w_next = ST_SCAN;
      end
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) w_next = ST_LAUNCH;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    if (w_wdog_tc) w_next = ST_DONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
      r_buf        <= '0;
      r_slot       <= '0;
      r_launch_cnt <= '0;
      r_wdog       <= '0;
      r_error      <= 1'b0;
      r_move_count <= '0;
    end else begin
      if (w_start_ok) begin
        r_move_count <= '0;
        r_error      <= 1'b0;
        r_launch_cnt <= LC_W'(LAUNCH_CYCLES - 1);
      end else if (r_state == ST_LAUNCH && r_launch_cnt != '0) begin
        r_launch_cnt <= r_launch_cnt - 1'b1;
      end

      // Watchdog is a down-counter reloaded throughout LAUNCH.
      if (r_state == ST_LAUNCH) begin
        r_wdog <= WD_W'(TIMEOUT - 1);
      end else if (w_wdog_active && r_wdog != '0) begin
        r_wdog <= r_wdog - 1'b1;
      end

      if (r_state == ST_SCAN && w_arb_valid && !w_wdog_tc) begin
        r_gnt_idx    <= w_arb_idx;
        r_gnt_onehot <= w_arb_grant;
        r_rr_ptr     <= w_arb_idx + 1'b1;
      end

      if (r_state == ST_CAPT) begin
        r_buf  <= w_col_words[r_gnt_idx];
        r_slot <= '0;
      end else if (w_advance && !w_last_slot) begin
        r_slot <= r_slot + 1'b1;
      end

      if (w_accept && r_move_count != 8'hFF) begin
        r_move_count <= r_move_count + 1'b1;
      end

      if (w_wdog_tc) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_board_move_sequencer.sv
// Directed bench for board_move_sequencer: behavioural column FIFOs, hand-built
// move words, and expected streams / timings written out as constants.
module tb_board_move_sequencer;
  import chess_move_pkg::*;

  localparam int TO = 64;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       start;
  logic [NCOL-1:0]            col_reset;
  logic [NCOL-1:0]            col_done;
  logic [NCOL-1:0]            col_empty;
  logic [NCOL-1:0]            col_rden;
  logic [NCOL*COL_WORD_W-1:0] col_data;
  logic                       move_valid;
  logic                       move_ready;
  logic [MOVE_W-1:0]          move_data;
  logic [7:0]                 move_count;
  logic                       busy;
  logic                       done;
  logic                       error;

  always #5 clk = ~clk;

  board_move_sequencer #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .col_reset  (col_reset),
    .col_done   (col_done),
    .col_empty  (col_empty),
    .col_rden   (col_rden),
    .col_data   (col_data),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_data  (move_data),
    .move_count (move_count),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [NCOL-1:0]   has;
  logic [MOVE_W-1:0] acc_q[$];
  logic [NCOL-1:0]   rden_q[$];
  logic [MOVE_W-1:0] exp_q[$];
  int cyc, launch_cnt, active_cnt, done_cyc, rden_cyc;
  bit saw_valid, stalled, reached;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MOVE_W-1:0] mv(input logic inv, input logic [5:0] fl,
                                           input logic [5:0] fr, input logic [5:0] to);
    return {inv, fl, fr, to};
  endfunction

  function automatic logic [COL_WORD_W-1:0] mk_word(
      input logic [MOVE_W-1:0] s0, input logic [MOVE_W-1:0] s1,
      input logic [MOVE_W-1:0] s2, input logic [MOVE_W-1:0] s3,
      input logic [MOVE_W-1:0] s4, input logic [MOVE_W-1:0] s5,
      input logic [MOVE_W-1:0] s6, input logic [MOVE_W-1:0] s7);
    return {s7, s6, s5, s4, s3, s2, s1, s0};
  endfunction

  task automatic set_col(input int i, input logic [COL_WORD_W-1:0] w);
    col_data[i*COL_WORD_W +: COL_WORD_W] = w;
    has[i]    = 1'b1;
    col_empty = ~has;
  endtask

  // Sample just after the falling edge (inputs already settled), then wait one cycle.
  task automatic tick();
    #1;
    cyc++;
    if (move_valid) saw_valid = 1'b1;
    if (move_valid && move_ready) acc_q.push_back(move_data);
    if (|col_rden) begin
      rden_q.push_back(col_rden);
      rden_cyc  = cyc;
      has       = has & ~col_rden;
      col_empty = ~has;
    end
    if (col_reset == '1) launch_cnt++;
    if (busy && col_reset == '0) active_cnt++;
    if (done && done_cyc < 0) done_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start      = 1'b0;
    launch_cnt = 0;
    active_cnt = 0;
    done_cyc   = -1;
    rden_cyc   = -1;
    saw_valid  = 1'b0;
    acc_q.delete();
    rden_q.delete();
  endtask

  task automatic run_until_done(input int budget, input string tag);
    for (int i = 0; i < budget && done_cyc < 0; i++) tick();
    chk({tag, " done"}, 32'(done), 1);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, " n_moves"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, " move"}, (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  logic [MOVE_W-1:0] INV_S, M0, M1, M2, MA, MB, MC;

  initial begin
    INV_S = mv(1'b1, 6'b0, 6'o0, 6'o0);
    M0 = mv(1'b0, 6'b000000, 6'o14, 6'o34);
    M1 = mv(1'b0, 6'b000001, 6'o15, 6'o35);
    M2 = mv(1'b0, 6'b010000, 6'o16, 6'o36);
    MA = mv(1'b0, 6'b100000, 6'o61, 6'o71);
    MB = mv(1'b0, 6'b000010, 6'o04, 6'o06);
    MC = mv(1'b0, 6'b001000, 6'o41, 6'o52);

    reset = 1'b1; start = 1'b0; move_ready = 1'b1;
    col_done = '1; has = '0; col_empty = '1; col_data = '0;
    cyc = 0; done_cyc = -1; rden_cyc = -1; launch_cnt = 0; active_cnt = 0;
    @(negedge clk);
    tick();
    tick();
    chk("rst move_valid", 32'(move_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst error", 32'(error), 0);
    chk("rst move_count", 32'(move_count), 0);
    chk("rst col_reset", 32'(col_reset), 0);
    chk("rst col_rden", 32'(col_rden), 0);
    reset = 1'b0;
    tick();

    // Column 3: three valid moves then five invalid slots.
    set_col(3, mk_word(M0, M1, M2, INV_S, INV_S, INV_S, INV_S, INV_S));
    pulse_start();
    run_until_done(200, "t1");
    exp_q = '{M0, M1, M2};
    chk_stream("t1");
    chk("t1 move_count", 32'(move_count), 3);
    chk("t1 rden pulses", rden_q.size(), 1);
    chk("t1 rden col", (rden_q.size() > 0) ? 32'(rden_q[0]) : 32'hFFFF_FFFF, 32'h08);
    chk("t1 error", 32'(error), 0);
    chk("t1 busy", 32'(busy), 0);

    // Column 2: every slot invalid; rr pointer ends at 3.
    set_col(2, mk_word(INV_S, INV_S, INV_S, INV_S, INV_S, INV_S, INV_S, INV_S));
    pulse_start();
    run_until_done(200, "t4");
    chk("t4 saw_valid", 32'(saw_valid), 0);
    chk("t4 move_count", 32'(move_count), 0);
    chk("t4 rden col", (rden_q.size() > 0) ? 32'(rden_q[0]) : 32'hFFFF_FFFF, 32'h04);
    chk("t4 rden_to_done", done_cyc - rden_cyc, 11);

    // Columns 2 and 5 with pointer at 3: column 5 first, slot 7 of column 2 last.
    set_col(5, mk_word(MA, INV_S, INV_S, INV_S, INV_S, INV_S, INV_S, INV_S));
    set_col(2, mk_word(MB, INV_S, INV_S, INV_S, INV_S, INV_S, INV_S, MC));
    pulse_start();
    run_until_done(200, "t2");
    exp_q = '{MA, MB, MC};
    chk_stream("t2");
    chk("t2 move_count", 32'(move_count), 3);
    chk("t2 rden n", rden_q.size(), 2);
    chk("t2 rden first", (rden_q.size() > 0) ? 32'(rden_q[0]) : 32'hFFFF_FFFF, 32'h20);
    chk("t2 rden second", (rden_q.size() > 1) ? 32'(rden_q[1]) : 32'hFFFF_FFFF, 32'h04);

    // Backpressure on slot 1; pointer at 3 so column 3 wins over column 2.
    set_col(3, mk_word(M0, M1, M2, INV_S, INV_S, INV_S, INV_S, INV_S));
    set_col(2, mk_word(INV_S, INV_S, INV_S, INV_S, INV_S, INV_S, INV_S, INV_S));
    pulse_start();
    stalled = 1'b0;
    for (int i = 0; i < 200 && !stalled; i++) begin
      if (move_valid && move_data == M1) begin
        move_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
          tick();
          chk("t3 hold valid", 32'(move_valid), 1);
          chk("t3 hold data", 32'(move_data), 32'(M1));
          chk("t3 hold count", 32'(move_count), 1);
        end
        move_ready = 1'b1;
        stalled    = 1'b1;
      end else begin
        tick();
      end
    end
    chk("t3 stall reached", 32'(stalled), 1);
    run_until_done(200, "t3");
    exp_q = '{M0, M1, M2};
    chk_stream("t3");
    chk("t3 move_count", 32'(move_count), 3);
    chk("t3 rden first", (rden_q.size() > 0) ? 32'(rden_q[0]) : 32'hFFFF_FFFF, 32'h08);
    chk("t3 rden second", (rden_q.size() > 1) ? 32'(rden_q[1]) : 32'hFFFF_FFFF, 32'h04);

    // Async reset while a move is being offered.
    set_col(3, mk_word(M0, M1, M2, INV_S, INV_S, INV_S, INV_S, INV_S));
    move_ready = 1'b0;
    pulse_start();
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      if (move_valid) reached = 1'b1;
      else tick();
    end
    chk("t5 emit reached", 32'(reached), 1);
    #2 reset = 1'b1;
    #1;
    chk("t5 move_valid", 32'(move_valid), 0);
    chk("t5 col_rden", 32'(col_rden), 0);
    chk("t5 busy", 32'(busy), 0);
    chk("t5 done", 32'(done), 0);
    chk("t5 col_reset", 32'(col_reset), 0);
    @(negedge clk);
    reset      = 1'b0;
    move_ready = 1'b1;
    has        = '0;
    col_empty  = '1;
    tick();
    pulse_start();
    run_until_done(200, "t5");
    chk("t5 launch cycles", launch_cnt, 2);
    chk("t5 n_moves", acc_q.size(), 0);

    // Watchdog: nothing to read and columns never finish.
    col_done = '0;
    pulse_start();
    run_until_done(200, "t6");
    chk("t6 active cycles", active_cnt, TO);
    chk("t6 error", 32'(error), 1);
    chk("t6 move_valid", 32'(move_valid), 0);
    col_done = '1;
    pulse_start();
    chk("t6 error cleared", 32'(error), 0);
    chk("t6 busy relaunch", 32'(busy), 1);
    run_until_done(200, "t6b");
    chk("t6b error", 32'(error), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/board_move_sequencer.md
Name: board_move_sequencer

Overview:
Board-level controller for the eight column move-generation units. It launches a generation pass by pulsing the column reset, then round-robin arbitrates the eight column FIFOs. Each 152-bit FIFO word is unpacked into eight 19-bit move slots, and invalid slots are dropped. Valid moves stream out one per cycle on a valid/ready port to the search logic.

Parameters:
NCOL, 8, number of column units served
SLOTS, 8, 19-bit move slots per column FIFO word
MOVE_W, 19, move width: [18 invalid][17 promote][16 pawn move][15 pawn 2sq][14 en passant][13 castle][12 capture][11:6 from][5:0 to]
LAUNCH_CYCLES, 2, cycles col_reset is held high per pass
TIMEOUT, 4096, watchdog cycles allowed per pass before error

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a pass, accepted only in IDLE/DONE
col_reset  out  NCOL  synchronous reset to each column unit, high during LAUNCH
col_done  in  NCOL  column done flags
col_empty  in  NCOL  column FIFO empty flags
col_rden  out  NCOL  one-hot FIFO read enable
col_data  in  NCOL*SLOTS*MOVE_W  column FIFO words; column i occupies [i*152 +: 152]
move_valid  out  1  move_data valid
move_ready  in  1  downstream accept
move_data  out  MOVE_W  current move
move_count  out  8  valid moves emitted this pass, saturates at 255
busy  out  1  high outside IDLE/DONE
done  out  1  high in DONE until next start
error  out  1  watchdog expired; sticky until next start

Behaviour:
- Reset (async) forces: state IDLE, all outputs 0, rr pointer 0, counters 0.
- Reset asserted mid-pass drops any buffered word and any unaccepted move.
- States: IDLE, LAUNCH, SCAN, READ, CAPT, EMIT, DONE.
- IDLE/DONE + start:
  - clear move_count and error;
  - go to LAUNCH.
  - start in any other state is ignored.
- LAUNCH:
  - col_reset = all ones for LAUNCH_CYCLES cycles;
  - then go to SCAN.
  - The watchdog counter is cleared on LAUNCH entry.
- SCAN:
  - Grant the first non-empty column at or after rr_ptr, wrapping 7->0.
  - Latch the grant and go to READ.
  - rr_ptr <= grant+1 mod NCOL.
  - If no column is non-empty and &col_done, go to DONE.
  - Otherwise stay in SCAN.
- READ: col_rden = one-hot(grant) for exactly one cycle; go to CAPT.
- CAPT:
  - FIFO read latency is 1 cycle: capture the granted column's word into a 152-bit buffer;
  - slot index <= 0;
  - go to EMIT.
- EMIT, one slot per cycle, slot 0 = bits [18:0] first:
  - invalid bit = 1: skip the slot; move_valid stays 0 for that cycle.
  - Valid slot: move_valid = 1 and move_data = slot. move_data is held stable while move_ready = 0.
  - Advance only on move_valid & move_ready.
  - On acceptance, move_count increments, saturating at 255.
  - After slot SLOTS-1 is consumed or skipped, go to SCAN.
- Watchdog:
  - Counts every cycle in SCAN/READ/CAPT/EMIT.
  - At TIMEOUT: error = 1, go to DONE, and move_valid drops immediately.
- busy = state not in {IDLE, DONE}.
- col_rden never asserts for a column whose col_empty is 1 in the SCAN grant cycle.

Decomposition:
- Package chess_move_pkg holds:
  - MOVE_W, the flag bit positions (INV=18 … CAP=12), FROM/TO field ranges;
  - the COL_WORD_W=152 constant;
  - the state encoding.
- Sub-module rr_arbiter8: combinational priority rotate from rr_ptr over ~col_empty, returning a one-hot grant plus a valid bit.

Test Plan:
1. Column 3 word with slots 0..2 valid (from=6'o14, to=6'o34 …) and slots 3..7 invalid, all col_done=1 -> 3 moves in slot order, move_count=3, col_rden[3] pulses once, done=1.
2. Columns 2 and 5 non-empty, rr_ptr=3 -> column 5 served first, then column 2; rr_ptr ends at 3.
3. move_ready=0 for 4 cycles on slot 1 -> move_data/move_valid unchanged across those cycles, no count increment, then resume.
4. Word with all 8 invalid bits set -> move_valid never asserts, move_count unchanged, returns to SCAN after 8 cycles.
5. reset asserted asynchronously mid-EMIT -> move_valid, col_rden, busy all 0 before the next edge; state IDLE; start then relaunches with col_reset high for 2 cycles.
6. col_done stuck 0, all FIFOs empty, TIMEOUT=64 -> error=1 and done=1 after 64 cycles; the next start clears error.
